// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl
//   Moves the MiSTer ROM download (ioctl index 0) into the core's four ROM
//   regions. Each accepted byte is decoded to a region and presented on a
//   shared write bus, while HPS is held off with ioctl_wait. The game core
//   stays in reset until the image is complete, then rom_ready is raised.
//
// Handshake (ROM write bus): wr_req rises one cycle after an accepted
//   ioctl_wr. wr_sel/wr_addr/wr_data stay stable while wr_req is high. A
//   single-cycle wr_ack completes the write; wr_req and ioctl_wait fall on the
//   next cycle. If no ack arrives within ACK_TIMEOUT cycles of wr_req rising,
//   the byte is dropped and err[1] is set. wr_ack outside a pending write is
//   ignored.
//
// Ports:
//   clk_sys, reset       system clock, async active-high reset
//   ioctl_download       HPS download active
//   ioctl_index          download index (only 0 is handled)
//   ioctl_wr             one-cycle byte strobe
//   ioctl_addr           byte address
//   ioctl_dout           byte data
//   ioctl_wait           back-pressure to HPS
//   wr_req               write request to the ROM bus
//   wr_sel               one-hot region select
//   wr_addr              region-relative address
//   wr_data              write data
//   wr_ack               ROM bus accepted the write (single-cycle pulse)
//   core_reset           reset to game core
//   rom_ready            image complete, core may run
//   byte_count           bytes accepted in the current download (saturating)
//   err                  sticky: [0] address out of range, [1] ack timeout
module rom_load_ctrl #(
  parameter logic [17:0] R1_BASE     = 18'h14000,
  parameter logic [17:0] R2_BASE     = 18'h18000,
  parameter logic [17:0] R3_BASE     = 18'h20000,
  parameter logic [17:0] ROM_END     = 18'h30000,
  parameter int          ACK_TIMEOUT = 64,
  parameter int          RST_HOLD    = 256
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [26:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        wr_req,
  output logic [3:0]  wr_sel,
  output logic [17:0] wr_addr,
  output logic [7:0]  wr_data,
  input  logic        wr_ack,
  output logic        core_reset,
  output logic        rom_ready,
  output logic [17:0] byte_count,
  output logic [1:0]  err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_HOLD  = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  localparam logic [15:0] TMO_LAST  = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);

  state_t      state_q, state_d;
  logic        active_q;
  logic        wait_d, req_d, core_reset_d, ready_d;
  logic [3:0]  sel_d;
  logic [17:0] addr_d, count_d;
  logic [7:0]  data_d;
  logic [1:0]  err_d;
  logic [15:0] tmo_q, tmo_d, hold_q, hold_d;

  logic        active, rise, addr_ok;
  logic [17:0] a18;
  logic [3:0]  dec_sel;
  logic [17:0] dec_off;

  assign active  = ioctl_download && (ioctl_index == 8'd0);
  assign rise    = active && !active_q;
  assign a18     = ioctl_addr[17:0];
  assign addr_ok = (ioctl_addr[26:18] == 9'd0) && (a18 < ROM_END);

  // Region decode; the subtraction never wraps because each branch is only
  // taken once the address is at or above that region's base.
  always_comb begin
    dec_sel = 4'b0001;
    dec_off = a18;
    if (a18 < R1_BASE) begin
      dec_sel = 4'b0001;
      dec_off = a18;
    end else if (a18 < R2_BASE) begin
      dec_sel = 4'b0010;
      dec_off = a18 - R1_BASE;
    end else if (a18 < R3_BASE) begin
      dec_sel = 4'b0100;
      dec_off = a18 - R2_BASE;
    end else begin
      dec_sel = 4'b1000;
      dec_off = a18 - R3_BASE;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = ioctl_wait;
    req_d        = wr_req;
    sel_d        = wr_sel;
    addr_d       = wr_addr;
    data_d       = wr_data;
    core_reset_d = core_reset;
    ready_d      = rom_ready;
    count_d      = byte_count;
    err_d        = err;
    tmo_d        = tmo_q;
    hold_d       = hold_q;

    case (state_q)
      S_IDLE, S_HOLD, S_RUN: begin
        if (rise) begin
          // New download: restart the image from scratch.
          state_d      = S_LOAD;
          count_d      = 18'd0;
          err_d        = 2'b00;
          ready_d      = 1'b0;
          core_reset_d = 1'b1;
        end else if (state_q == S_HOLD) begin
          if (hold_q == HOLD_LAST) begin
            state_d      = S_RUN;
            core_reset_d = 1'b0;
            ready_d      = 1'b1;
          end else begin
            hold_d = hold_q + 16'd1;
          end
        end
      end

      S_LOAD: begin
        if (!active) begin
          state_d      = S_HOLD;
          hold_d       = 16'd0;
          core_reset_d = 1'b1;
        end else if (ioctl_wr) begin
          if (!addr_ok) begin
            err_d[0] = 1'b1;
          end else begin
            state_d = S_WRITE;
            req_d   = 1'b1;
            wait_d  = 1'b1;
            sel_d   = dec_sel;
            addr_d  = dec_off;
            data_d  = ioctl_dout;
            tmo_d   = 16'd0;
          end
        end
      end

      S_WRITE: begin
        // ioctl_wr here is a protocol violation and is deliberately ignored.
        if (wr_ack || (tmo_q == TMO_LAST)) begin
          req_d  = 1'b0;
          wait_d = 1'b0;
          if (wr_ack) begin
            if (byte_count != 18'h3FFFF) count_d = byte_count + 18'd1;
          end else begin
            err_d[1] = 1'b1;
          end
          // A download that ended mid-write goes straight to HOLD once the
          // pending byte is resolved.
          if (active) begin
            state_d = S_LOAD;
          end else begin
            state_d      = S_HOLD;
            hold_d       = 16'd0;
            core_reset_d = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      active_q   <= 1'b0;
      ioctl_wait <= 1'b0;
      wr_req     <= 1'b0;
      wr_sel     <= 4'b0000;
      wr_addr    <= 18'd0;
      wr_data    <= 8'd0;
      core_reset <= 1'b1;
      rom_ready  <= 1'b0;
      byte_count <= 18'd0;
      err        <= 2'b00;
      tmo_q      <= 16'd0;
      hold_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      active_q   <= active;
      ioctl_wait <= wait_d;
      wr_req     <= req_d;
      wr_sel     <= sel_d;
      wr_addr    <= addr_d;
      wr_data    <= data_d;
      core_reset <= core_reset_d;
      rom_ready  <= ready_d;
      byte_count <= count_d;
      err        <= err_d;
      tmo_q      <= tmo_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: doc/rom_load_ctrl.md
Name: rom_load_ctrl

Overview:
- Sequences the MiSTer ROM download (ioctl index 0) into the core's ROM regions: main CPU, sound CPU, tile gfx, sprite gfx.
- Decodes each byte to one region, presents it on a shared write bus with a req/ack handshake, and back-pressures HPS via ioctl_wait.
- Holds the game core in reset until the image is fully written, then asserts rom_ready.
- Sits between hps_io and the core's ROM/BRAM write ports.

Parameters:
- R1_BASE, 18'h14000, first address of region 1 (sound CPU); region 0 = [0, R1_BASE)
- R2_BASE, 18'h18000, first address of region 2 (tile gfx)
- R3_BASE, 18'h20000, first address of region 3 (sprite gfx)
- ROM_END, 18'h30000, first address past region 3
- ACK_TIMEOUT, 64, cycles to wait for wr_ack before dropping a byte
- RST_HOLD, 256, core_reset cycles held after download end

Ports:
- clk_sys in 1 system clock
- reset in 1 async active-high reset
- ioctl_download in 1 HPS download active
- ioctl_index in 8 download index; only 8'd0 is handled
- ioctl_wr in 1 one-cycle byte strobe
- ioctl_addr in 27 byte address
- ioctl_dout in 8 byte data
- ioctl_wait out 1 back-pressure to HPS
- wr_req out 1 write request to ROM bus
- wr_sel out 4 one-hot region select
- wr_addr out 18 region-relative address
- wr_data out 8 write data
- wr_ack in 1 ROM bus accepted the write (single-cycle pulse)
- core_reset out 1 reset to game core
- rom_ready out 1 image complete, core may run
- byte_count out 18 bytes accepted in current download
- err out 2 sticky: [0] address >= ROM_END, [1] ack timeout

Behaviour:
- Reset: state IDLE; ioctl_wait=0, wr_req=0, wr_sel=0, wr_addr=0, wr_data=0, core_reset=1, rom_ready=0, byte_count=0, err=0. All outputs registered.
- Active download = ioctl_download && ioctl_index==0. Other indices are ignored entirely (no wait, no writes).
- IDLE: on rising edge of active download -> LOAD; clear byte_count, err; rom_ready=0, core_reset=1.
- LOAD: on ioctl_wr, latch addr/data:
  - addr[26:18]!=0 or addr>=ROM_END: drop, set err[0]; stay LOAD; no wait.
  - otherwise -> WRITE next cycle; ioctl_wait=1 from the cycle after ioctl_wr; wr_req=1.
  - Region decode: addr<R1_BASE -> sel 4'b0001, offset addr; <R2_BASE -> 4'b0010, addr-R1_BASE; <R3_BASE -> 4'b0100, addr-R2_BASE; else 4'b1000, addr-R3_BASE. 18-bit subtraction, no wrap possible.
- WRITE: hold wr_req/sel/addr/data stable until wr_ack.
  - On wr_ack: wr_req=0 and ioctl_wait=0 next cycle; byte_count+1 (saturates at 18'h3FFFF); -> LOAD.
  - Timeout counter starts at wr_req assert. At ACK_TIMEOUT cycles without ack: drop byte, set err[1], release wait, -> LOAD.
  - wr_ack in LOAD/IDLE is ignored.
  - ioctl_wr arriving while in WRITE is a protocol violation (HPS must honour wait) and is ignored.
- Download falls while in WRITE: complete the pending write (ack or timeout) first, then -> HOLD.
- Download falls in LOAD -> HOLD.
- HOLD: core_reset=1; count RST_HOLD cycles -> RUN.
- RUN: core_reset=0, rom_ready=1. New active download rising edge -> LOAD with the same clear rules; core_reset=1 and rom_ready=0 take effect the next cycle.
- Async reset in any state aborts immediately: wr_req drops and the partial image is not marked ready.
- Latency: ioctl_wr to wr_req = 1 cycle; wr_ack to ioctl_wait low = 1 cycle.

Test Plan:
- Reset then idle -> core_reset=1, rom_ready=0, all others 0; ioctl_wr with index 1 produces no wr_req and no wait.
- Download index 0, write addr 18'h00010 data 8'hA5, ack after 3 cycles -> wr_sel=0001, wr_addr=18'h00010, wr_data=A5; ioctl_wait high for 4 cycles; byte_count=1.
- Bytes to 18'h14000, 18'h17FFF, 18'h18000, 18'h2FFFF -> sel 0010/0000, 0010/3FFF, 0100/0000, 1000/FFFF respectively.
- Byte to 18'h30000 and to 27'h0040000 -> no wr_req, err[0]=1, byte_count unchanged.
- wr_ack withheld -> after 64 cycles wr_req=0, ioctl_wait=0, err[1]=1; next byte proceeds normally.
- Drop download mid-WRITE, ack 5 cycles later -> write completes; core_reset stays high 256 more cycles, then rom_ready=1. Re-download -> rom_ready=0 next cycle.
